rob_marker_tracker: RTL and testbench
=====================================

// Module: rob_marker_tracker
// PURPOSE
//  Synthesizable front end of the taint-sync monitor. Watches the ROB commit (dequeue) slots and decodes
//  INFO_* marker instructions (addi x0,x0,imm: inst[19:0]==20'h02013, inst[31:24]==0, code=inst[23:20]).
//  Timestamps each marker and queues it as an event record for the logging consumer.
//  Also tracks the current test phase and raises tsx_done / sim_exit for the bench.
// PARAMETERS
//  COMMIT_W    2   commit slots per cycle (slot 0 is oldest)
//  ID_W        7   ROB index width
//  TS_W        32  cycle timestamp width
//  FIFO_DEPTH  8   event queue entries (power of 2, >= COMMIT_W)
//  DONE_DELAY  3   cycles from trigger marker to tsx_done
// PORTS
//  clock       in   1              clock
//  reset       in   1              reset, synchronous, active-low
//  cmt_valid   in   COMMIT_W       slot i committing this cycle
//  cmt_inst    in   32*COMMIT_W    slot i instruction word (bits [32i+31:32i])
//  cmt_id      in   ID_W*COMMIT_W  slot i ROB index
//  ev_valid    out  1              event record available
//  ev_ready    in   1              consumer accepts head record
//  ev_code     out  4              marker code 0x0..0xE (0x0 VCTM_START ... 0xE SIM_EXIT)
//  ev_id       out  ID_W           ROB index of the marker
//  ev_time     out  TS_W           cycle count at commit
//  phase       out  3              0 IDLE,1 INIT,2 TRAIN,3 BIM,4 VCTM,5 DELAY,6 TEXE,7 LEAK
//  tsx_done    out  1              sticky; transaction window closed
//  sim_exit    out  1              sticky; SIM_EXIT committed
//  overflow    out  1              sticky; at least one event was dropped
//  proto_err   out  1              sticky; END marker did not match the current phase
// BEHAVIOUR
//  - Reset (reset==0 at posedge): every output is 0, phase=IDLE, FIFO flushed, timestamp=0, countdown idle.
//    Applies mid-operation: in-flight records are lost, nothing is reported as dropped.
//  - Timestamp: free-running, +1 per cycle out of reset, wraps modulo 2^TS_W.
//    Records carry the value in the commit cycle.
//  - Decode: a slot is a marker iff cmt_valid[i], the pattern matches, and code<=0xE.
//    Code 0xF and all non-markers are ignored.
//  - Enqueue: markers of one cycle are written in slot order, write latency 1; ev_valid rises the next cycle at the earliest.
//    Free space is DEPTH-count, with no credit for a pop in the same cycle.
//    Slots beyond the free space are dropped; overflow is set.
//  - Dequeue: handshake is ev_valid&&ev_ready. ev_* hold stable while ev_valid&&!ev_ready.
//    Push and pop in one cycle: count += pushes - pop.
//  - Phase FSM, applied per marker in slot order within a cycle:
//    - X_START from any phase -> phase X. START while non-IDLE also sets proto_err.
//    - X_END with phase==X -> IDLE. X_END with phase!=X -> phase unchanged, proto_err=1.
//  - tsx_done: a committed VCTM_END or TEXE_START loads the countdown.
//    tsx_done=1 exactly DONE_DELAY cycles after that commit cycle, then stays until reset.
//    Re-triggers while counting or done are ignored.
//  - sim_exit: SIM_EXIT is enqueued like other markers; sim_exit=1 next cycle.
//    Later slots of that cycle and all later markers are neither enqueued nor decoded.
//    Draining continues normally.
// CONFIGURATION
//  ROB_MARKER_PHASE_CYC_EN
//  - Defined: adds output phase_cyc [7*TS_W], saturating per-phase cycle counters for INIT..LEAK.
//    A counter increments each cycle the registered phase equals that phase. Cleared by reset.
//  - Undefined: the port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package rob_marker_pkg:
//    - marker_code_e: 15 codes, plus the helpers is_start(code), to_phase(code).
//    - phase_e: 8 phases.
//    - MARKER_LO=20'h02013.
//    - event_t struct: code, id, time.
//  - Sub-module rob_marker_fifo: COMMIT_W-write / 1-read circular queue with pointer wrap, count and free outputs.
// TESTING
//  - Reset then idle 10 cycles -> ev_valid=0, phase=IDLE, flags=0, with reset held low mid-queue -> FIFO empty next cycle.
//  - Slot0 INIT_START (32'h00802013) at ts=5 -> ev {code 8, id, time 5} valid at ts=6; phase=INIT from ts=6.
//  - Slot0 VCTM_START and slot1 VCTM_END in one cycle -> two records in order, phase ends IDLE.
//    tsx_done rises 3 cycles later; a second VCTM_END changes nothing.
//  - ev_ready=0, 5 cycles of 2 markers each into DEPTH 8 -> 8 records kept in order, 2 dropped, overflow=1.
//    Records drain in order once ev_ready=1.
//  - DELAY_END while phase=TEXE -> proto_err=1, phase stays TEXE, record still queued.
//  - SIM_EXIT in slot0 with TRAIN_START in slot1 -> only the exit record is queued, sim_exit=1 next cycle.
//    A later INIT_START is ignored.

Source files
------------

// File: rtl/rob_marker_pkg.sv
// Shared types for the ROB marker tracker: marker codes, test phases and the event record.
package rob_marker_pkg;

    localparam logic [19:0] MARKER_LO = 20'h02013;
    localparam int EV_ID_W = 7;
    localparam int EV_TS_W = 32;

    // Even codes open a phase, the following odd code closes it; 0xE stops the monitor.
    typedef enum logic [3:0] {
        VCTM_START  = 4'h0,
        VCTM_END    = 4'h1,
        DELAY_START = 4'h2,
        DELAY_END   = 4'h3,
        TEXE_START  = 4'h4,
        TEXE_END    = 4'h5,
        LEAK_START  = 4'h6,
        LEAK_END    = 4'h7,
        INIT_START  = 4'h8,
        INIT_END    = 4'h9,
        TRAIN_START = 4'hA,
        TRAIN_END   = 4'hB,
        BIM_START   = 4'hC,
        BIM_END     = 4'hD,
        SIM_EXIT    = 4'hE
    } marker_code_e;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_TRAIN = 3'd2,
        PH_BIM   = 3'd3,
        PH_VCTM  = 3'd4,
        PH_DELAY = 3'd5,
        PH_TEXE  = 3'd6,
        PH_LEAK  = 3'd7
    } phase_e;

    typedef struct packed {
        marker_code_e         code;
        logic [EV_ID_W-1:0]   id;
        logic [EV_TS_W-1:0]   stamp;
    } event_t;

    function automatic logic is_marker(input logic [31:0] inst);
        return (inst[19:0] == MARKER_LO) && (inst[31:24] == 8'h00) && (inst[23:20] != 4'hF);
    endfunction

    function automatic logic is_start(input marker_code_e code);
        logic [3:0] raw;
        raw = code;
        return (code != SIM_EXIT) && !raw[0];
    endfunction

    function automatic phase_e to_phase(input marker_code_e code);
        phase_e ph;
        case (code)
            VCTM_START,  VCTM_END:  ph = PH_VCTM;
            DELAY_START, DELAY_END: ph = PH_DELAY;
            TEXE_START,  TEXE_END:  ph = PH_TEXE;
            LEAK_START,  LEAK_END:  ph = PH_LEAK;
            INIT_START,  INIT_END:  ph = PH_INIT;
            TRAIN_START, TRAIN_END: ph = PH_TRAIN;
            BIM_START,   BIM_END:   ph = PH_BIM;
            default:                ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/rob_marker_fifo.sv
// Multi-write / single-read circular event queue; writes land in slot order behind the write pointer.
module rob_marker_fifo
    import rob_marker_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COMMIT_W-1:0]        push,
    input  event_t [COMMIT_W-1:0]      wr_data,
    input  logic                       pop,
    output event_t                     rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    event_t         mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  offset;
    logic [AW-1:0]  wr_addr [COMMIT_W];
    logic [CNT_W-1:0] n_push;
    logic           pop_ok;

    // Only pushed slots consume an address, so accepted records stay contiguous.
    always_comb begin
        offset = '0;
        n_push = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            wr_addr[i] = wptr + offset;
            if (push[i]) begin
                offset = offset + 1'b1;
                n_push = n_push + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (push[i]) mem[wr_addr[i]] <= wr_data[i];
        end
    end

    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + n_push[AW-1:0];
            if (pop_ok) rptr <= rptr + 1'b1;
            count <= count + n_push - {{AW{1'b0}}, pop_ok};
        end
    end

    assign rd_data = mem[rptr];
    assign free    = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/rob_marker_tracker.sv
// Decodes INFO_* markers at ROB commit, timestamps and queues them, and tracks the test phase.
// Optional ROB_MARKER_PHASE_CYC_EN adds per-phase saturating cycle counters on phase_cyc.
module rob_marker_tracker
    import rob_marker_pkg::*;
#(
    parameter int COMMIT_W   = 2,
    parameter int ID_W       = EV_ID_W,
    parameter int TS_W       = EV_TS_W,
    parameter int FIFO_DEPTH = 8,
    parameter int DONE_DELAY = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COMMIT_W-1:0]      cmt_valid,
    input  logic [32*COMMIT_W-1:0]   cmt_inst,
    input  logic [ID_W*COMMIT_W-1:0] cmt_id,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [3:0]               ev_code,
    output logic [ID_W-1:0]          ev_id,
    output logic [TS_W-1:0]          ev_time,
    output logic [2:0]               phase,
    output logic                     tsx_done,
    output logic                     sim_exit,
    output logic                     overflow,
    output logic                     proto_err
`ifdef ROB_MARKER_PHASE_CYC_EN
    ,
    output logic [7*TS_W-1:0]        phase_cyc
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DLY_W = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;

    logic [TS_W-1:0]        ts_q;
    phase_e                 phase_q;
    phase_e                 phase_nxt;
    logic                   done_q;
    logic                   armed_q;
    logic [DLY_W-1:0]       dly_q;
    logic                   exit_q;
    logic                   ovf_q;
    logic                   perr_q;

    logic [COMMIT_W-1:0]    push;
    event_t [COMMIT_W-1:0]  wr_data;
    event_t                 head;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       free;
    logic                   pop;
    logic                   perr_set;
    logic                   drop;
    logic                   exit_set;
    logic                   trig;
    logic                   blocked;
    marker_code_e           code;
    int                     accepted;

    // Slots are walked oldest first so phase changes and drops follow commit order;
    // once SIM_EXIT is seen, younger slots are not decoded at all.
    always_comb begin
        push      = '0;
        wr_data   = '0;
        phase_nxt = phase_q;
        perr_set  = 1'b0;
        drop      = 1'b0;
        exit_set  = 1'b0;
        trig      = 1'b0;
        code      = VCTM_START;
        accepted  = 0;
        blocked   = exit_q;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (!blocked && cmt_valid[i] && is_marker(cmt_inst[32*i +: 32])) begin
                code = marker_code_e'(cmt_inst[32*i+20 +: 4]);
                wr_data[i] = '{code: code, id: cmt_id[ID_W*i +: ID_W], stamp: ts_q};
                if (accepted < int'(free)) begin
                    push[i]  = 1'b1;
                    accepted = accepted + 1;
                end else begin
                    drop = 1'b1;
                end
                if (code == SIM_EXIT) begin
                    exit_set = 1'b1;
                    blocked  = 1'b1;
                end else if (is_start(code)) begin
                    if (phase_nxt != PH_IDLE) perr_set = 1'b1;
                    phase_nxt = to_phase(code);
                end else if (phase_nxt == to_phase(code)) begin
                    phase_nxt = PH_IDLE;
                end else begin
                    perr_set = 1'b1;
                end
                if (code == VCTM_END || code == TEXE_START) trig = 1'b1;
            end
        end
    end

    // The countdown arms once; further triggers are ignored until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ts_q    <= '0;
            phase_q <= PH_IDLE;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
            dly_q   <= '0;
            exit_q  <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            phase_q <= phase_nxt;
            if (exit_set) exit_q <= 1'b1;
            if (drop)     ovf_q  <= 1'b1;
            if (perr_set) perr_q <= 1'b1;
            if (armed_q) begin
                if (dly_q == DLY_W'(1)) begin
                    done_q  <= 1'b1;
                    armed_q <= 1'b0;
                end else begin
                    dly_q <= dly_q - 1'b1;
                end
            end else if (trig && !done_q) begin
                if (DONE_DELAY <= 1) begin
                    done_q <= 1'b1;
                end else begin
                    armed_q <= 1'b1;
                    dly_q   <= DLY_W'(DONE_DELAY - 1);
                end
            end
        end
    end

    rob_marker_fifo #(
        .COMMIT_W (COMMIT_W),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .free    (free)
    );

    // Head fields are forced to zero while empty so stale memory never shows.
    assign ev_valid  = (count != '0);
    assign pop       = ev_valid && ev_ready;
    assign ev_code   = ev_valid ? 4'(head.code) : 4'h0;
    assign ev_id     = ev_valid ? head.id       : '0;
    assign ev_time   = ev_valid ? head.stamp    : '0;
    assign phase     = phase_q;
    assign tsx_done  = done_q;
    assign sim_exit  = exit_q;
    assign overflow  = ovf_q;
    assign proto_err = perr_q;

`ifdef ROB_MARKER_PHASE_CYC_EN
    logic [TS_W-1:0] cyc_cnt [7];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int p = 0; p < 7; p++) cyc_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < 7; p++) begin
                if (phase_q == phase_e'(3'(p + 1)) && cyc_cnt[p] != '1)
                    cyc_cnt[p] <= cyc_cnt[p] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 7; g++) begin : g_phase_cyc
        assign phase_cyc[g*TS_W +: TS_W] = cyc_cnt[g];
    end
`endif

endmodule

// File: tb/tb_rob_marker_tracker.sv
// Scoreboard bench: a queue-based reference model predicts records and flags; a negedge monitor checks.
`timescale 1ns/1ps
module tb_rob_marker_tracker;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cmt_valid = '0;
    logic [63:0] cmt_inst = '0;
    logic [13:0] cmt_id = '0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic [6:0]  ev_id;
    logic [31:0] ev_time;
    logic [2:0]  phase;
    logic        tsx_done;
    logic        sim_exit;
    logic        overflow;
    logic        proto_err;
`ifdef ROB_MARKER_PHASE_CYC_EN
    logic [223:0] phase_cyc;
`endif

    rob_marker_tracker dut (
        .clock     (clock),
        .reset     (reset),
        .cmt_valid (cmt_valid),
        .cmt_inst  (cmt_inst),
        .cmt_id    (cmt_id),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_id     (ev_id),
        .ev_time   (ev_time),
        .phase     (phase),
        .tsx_done  (tsx_done),
        .sim_exit  (sim_exit),
        .overflow  (overflow),
        .proto_err (proto_err)
`ifdef ROB_MARKER_PHASE_CYC_EN
        ,
        .phase_cyc (phase_cyc)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int     code;
        int     id;
        longint stamp;
    } rec_t;

    rec_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    bit     live = 0;
    bit     finished = 0;

    // Phase entered/left by each marker code 0..13 (IDLE=0 ... LEAK=7).
    int     ph_of [14] = '{4, 4, 5, 5, 6, 6, 7, 7, 1, 1, 2, 2, 3, 3};

    int     m_phase = 0;
    bit     m_trig = 0;
    longint m_trig_ts = 0;
    bit     m_exit = 0;
    bit     m_ovf = 0;
    bit     m_perr = 0;
    longint cur_ts = 0;

    logic [1:0]  d_valid = '0;
    logic [63:0] d_inst = '0;
    logic [13:0] d_id = '0;
    logic        d_rst = 1'b0;
    longint      d_ts = 0;
    int          d_occ = 0;

    function automatic logic [31:0] mk(input int c);
        return {8'h00, 4'(c), 20'h02013};
    endfunction

    // Applies the rules to the inputs that were present in the cycle that just ended.
    task automatic model_edge();
        int          accepted;
        int          code;
        logic [31:0] inst;
        if (!d_rst) begin
            exp_q.delete();
            m_phase = 0; m_trig = 0; m_exit = 0; m_ovf = 0; m_perr = 0;
            cur_ts = 0;
            live = 1;
            return;
        end
        if (!live) return;
        accepted = 0;
        for (int i = 0; i < 2; i++) begin
            inst = d_inst[32*i +: 32];
            if (m_exit || !d_valid[i]) continue;
            if (inst[19:0] != 20'h02013 || inst[31:24] != 8'h00 || inst[23:20] == 4'hF) continue;
            code = int'(inst[23:20]);
            if (accepted < DEPTH - d_occ) begin
                exp_q.push_back('{code, int'(d_id[7*i +: 7]), d_ts});
                accepted++;
            end else begin
                m_ovf = 1;
            end
            if (code == 14) begin
                m_exit = 1;
            end else if (code % 2 == 0) begin
                if (m_phase != 0) m_perr = 1;
                m_phase = ph_of[code];
            end else if (m_phase == ph_of[code]) begin
                m_phase = 0;
            end else begin
                m_perr = 1;
            end
            if ((code == 1 || code == 4) && !m_trig) begin
                m_trig = 1;
                m_trig_ts = d_ts;
            end
        end
        cur_ts++;
    endtask

    task automatic apply_stimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                                  input logic [6:0] id0, input logic [6:0] id1,
                                  input logic rdy, input logic rst_n);
        @(posedge clock);
        #1;
        model_edge();
        cmt_valid = v;
        cmt_inst  = {i1, i0};
        cmt_id    = {id1, id0};
        ev_ready  = rdy;
        reset     = rst_n;
        d_valid   = v;
        d_inst    = {i1, i0};
        d_id      = {id1, id0};
        d_rst     = rst_n;
        d_ts      = cur_ts;
        d_occ     = exp_q.size();
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) apply_stimulus(2'b00, 32'h0, 32'h0, 7'd0, 7'd0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        apply_stimulus(2'b00, 32'h0, 32'h0, 7'd0, 7'd0, 1'b1, 1'b0);
    endtask

    task automatic check_output();
        bit          exp_valid;
        logic [6:0]  exp_flags;
        logic [6:0]  got_flags;
        exp_valid = (exp_q.size() != 0);
        vectors++;
        if (ev_valid !== exp_valid) begin
            miscompares++;
            $display("[TB] FAIL ev_valid at t=%0t: got %b expected %b", $time, ev_valid, exp_valid);
        end
        if (exp_valid && ev_valid) begin
            vectors++;
            if (ev_code !== 4'(exp_q[0].code) || ev_id !== 7'(exp_q[0].id) ||
                ev_time !== 32'(exp_q[0].stamp)) begin
                miscompares++;
                $display("[TB] FAIL record at t=%0t: got code=%h id=%0d time=%0d expected code=%h id=%0d time=%0d",
                         $time, ev_code, ev_id, ev_time, 4'(exp_q[0].code), exp_q[0].id, exp_q[0].stamp);
            end
        end
        exp_flags = {3'(m_phase), m_trig && (cur_ts >= m_trig_ts + 3), m_exit, m_ovf, m_perr};
        got_flags = {phase, tsx_done, sim_exit, overflow, proto_err};
        vectors++;
        if (got_flags !== exp_flags) begin
            miscompares++;
            $display("[TB] FAIL flags {phase,tsx_done,sim_exit,overflow,proto_err} at t=%0t: got %b expected %b",
                     $time, got_flags, exp_flags);
        end
        if (ev_valid && ev_ready && exp_valid) void'(exp_q.pop_front());
    endtask

    always @(negedge clock) begin
        if (live && !finished) check_output();
    end

    function automatic logic [31:0] rand_inst();
        int r;
        int c;
        r = int'($urandom_range(0, 99));
        if (r < 2)       c = 14;
        else if (r < 8)  c = 15;
        else             c = int'($urandom_range(0, 13));
        r = int'($urandom_range(0, 9));
        if (r == 0) return $urandom();
        if (r == 1) return mk(c) | 32'h0100_0000;
        if (r == 2) return mk(c) ^ 32'h0000_0001;
        return mk(c);
    endfunction

    initial begin
        do_reset();
        do_reset();
        idle(10, 1'b1);

        do_reset();
        idle(5, 1'b1);
        apply_stimulus(2'b01, mk(8), 32'h0, 7'd17, 7'd0, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);

        do_reset();
        apply_stimulus(2'b11, mk(0), mk(1), 7'd20, 7'd21, 1'b1, 1'b1);
        idle(5, 1'b1);
        apply_stimulus(2'b01, mk(1), 32'h0, 7'd22, 7'd0, 1'b1, 1'b1);
        idle(4, 1'b1);

        do_reset();
        for (int k = 0; k < 5; k++)
            apply_stimulus(2'b11, mk(8), mk(9), 7'(2*k), 7'(2*k + 1), 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(12, 1'b1);

        do_reset();
        apply_stimulus(2'b01, mk(4), 32'h0, 7'd40, 7'd0, 1'b1, 1'b1);
        apply_stimulus(2'b01, mk(3), 32'h0, 7'd41, 7'd0, 1'b1, 1'b1);
        idle(5, 1'b1);

        apply_stimulus(2'b11, mk(10), mk(12), 7'd50, 7'd51, 1'b0, 1'b1);
        apply_stimulus(2'b11, mk(13), mk(11), 7'd52, 7'd53, 1'b0, 1'b1);
        do_reset();
        idle(3, 1'b1);

        apply_stimulus(2'b11, mk(14), mk(10), 7'd60, 7'd61, 1'b1, 1'b1);
        idle(2, 1'b1);
        apply_stimulus(2'b01, mk(8), 32'h0, 7'd62, 7'd0, 1'b1, 1'b1);
        idle(4, 1'b1);

        for (int seg = 0; seg < 20; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
            do_reset();
            for (int c = 0; c < 150; c++) begin
                apply_stimulus(2'($urandom_range(0, 3)), rand_inst(), rand_inst(),
                               7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                               ($urandom_range(0, 99) < rdy_pct), 1'b1);
            end
            idle(12, 1'b1);
        end

        @(posedge clock);
        #1;
        finished = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
